regbank_scan_ctrl: RTL and testbench

//  Scan scheduler between the register bank and the multiplexed 7-seg display.

---
 rtl/regbank_scan_ctrl_pkg.sv | 21 ++
 rtl/regbank_scan_ctrl_if.sv | 28 ++
 rtl/regbank_scan_ctrl_scan_timer.sv | 26 ++
 rtl/regbank_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_regbank_scan_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/regbank_scan_ctrl_pkg.sv
// Shared definitions for the display scan scheduler:
// state encodings, digit width and default bank address width.
package regbank_pkg;

   localparam int BCD_W      = 4;
   localparam int ADDR_W_DEF = 3;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_SHOW  = 3'd3;
   localparam logic [2:0] ST_BLANK = 3'd4;

   // At least 2 bits so the "one cycle before done" compare always fits
   function automatic int cnt_w(input int maxc);
      int w;
      w = $clog2(maxc + 1);
      return (w < 2) ? 2 : w;
   endfunction

endpackage

// File: rtl/regbank_scan_ctrl_if.sv
// Register bank read port: request/address out, grant/data back.
// master = scan controller, slave = bank arbiter.
interface regbank_scan_ctrl_if
   import regbank_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) ();

   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_gnt;
   logic [BCD_W-1:0]  rd_data;

   modport master (
      output rd_req,
      output rd_addr,
      input  rd_gnt,
      input  rd_data
   );

   modport slave (
      input  rd_req,
      input  rd_addr,
      output rd_gnt,
      output rd_data
   );

endinterface

// File: rtl/regbank_scan_ctrl_scan_timer.sv
// Loadable down-counter; done marks the last cycle of an
// interval loaded with N (the count runs N..1).
module scan_timer #(
   parameter int W = 2
) (
   input  logic         clk_e,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] val,
   output logic [W-1:0] cnt,
   output logic         done
);

   always_ff @(posedge clk_e or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == W'(1));

endmodule

// File: rtl/regbank_scan_ctrl.sv
// Multiplexed 7-seg scan: read a bank register per digit, show, blank.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits.
module regbank_scan_ctrl
   import regbank_pkg::*;
#(
   parameter int NDIG      = 4,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int PRESCALE  = 50000,
   parameter int BLANK_CYC = 16,
   parameter int RD_LAT    = 1
) (
   input  logic              clk_e,
   input  logic              rst,
   input  logic              en,
   input  logic [ADDR_W-1:0] base_addr,
   regbank_scan_ctrl_if.master rd,
   output logic [NDIG-1:0]   an,
   output logic [BCD_W-1:0]  bcd,
   output logic              frame_done
);

   localparam int MAX1 = (RD_LAT > PRESCALE) ? RD_LAT : PRESCALE;
   localparam int MAXC = (MAX1 > BLANK_CYC) ? MAX1 : BLANK_CYC;
   localparam int CW   = cnt_w(MAXC);
   localparam int IW   = $clog2(NDIG);

   localparam logic [CW-1:0]   L_RD     = CW'(RD_LAT);
   localparam logic [CW-1:0]   L_SH     = CW'(PRESCALE);
   localparam logic [CW-1:0]   L_BL     = CW'(BLANK_CYC);
   localparam logic [CW-1:0]   C_TWO    = CW'(2);
   localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
   localparam logic [NDIG-1:0] AN_OFF   = '1;

   logic [2:0]        st;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     idx_nxt;
   logic [ADDR_W-1:0] base_q;
   logic              ld;
   logic [CW-1:0]     ld_val;
   logic [CW-1:0]     cnt;
   logic              done;
   logic              dark;

   assign idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;

   scan_timer #(.W(CW)) u_tmr (
      .clk_e (clk_e),
      .rst   (rst),
      .load  (ld),
      .val   (ld_val),
      .cnt   (cnt),
      .done  (done)
   );

   always_comb begin
      ld     = 1'b0;
      ld_val = L_RD;
      unique case (st)
         ST_REQ: begin
            ld     = rd.rd_gnt;
            ld_val = L_RD;
         end
         ST_WAIT: begin
            ld     = done;
            ld_val = L_SH;
         end
         ST_SHOW: begin
            ld     = done;
            ld_val = L_BL;
         end
         default: ;
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic lz;
   logic lz_n;

   // Still "all zeros so far" including the digit being latched now
   assign lz_n = ((idx == '0) ? 1'b1 : lz) && (rd.rd_data == '0);
   assign dark = lz_n && (idx != IDX_LAST);

   always_ff @(posedge clk_e or negedge rst) begin
      if (!rst) begin
         lz <= 1'b0;
      end else if (st == ST_WAIT && done) begin
         lz <= lz_n;
      end
   end
`else
   assign dark = 1'b0;
`endif

   always_ff @(posedge clk_e or negedge rst) begin
      if (!rst) begin
         st         <= ST_IDLE;
         idx        <= '0;
         base_q     <= '0;
         an         <= AN_OFF;
         bcd        <= '0;
         rd.rd_req  <= 1'b0;
         rd.rd_addr <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (st)
            ST_IDLE: begin
               an        <= AN_OFF;
               rd.rd_req <= 1'b0;
               if (en) begin
                  st         <= ST_REQ;
                  idx        <= '0;
                  base_q     <= base_addr;
                  rd.rd_addr <= base_addr;
                  rd.rd_req  <= 1'b1;
               end
            end
            ST_REQ: begin
               if (rd.rd_gnt) begin
                  st        <= ST_WAIT;
                  rd.rd_req <= 1'b0;
               end else if (!en) begin
                  st        <= ST_IDLE;
                  rd.rd_req <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (done) begin
                  st  <= ST_SHOW;
                  bcd <= rd.rd_data;
                  an  <= dark ? AN_OFF : ~(NDIG'(1) << idx);
               end
            end
            ST_SHOW: begin
               if (done) begin
                  st         <= ST_BLANK;
                  an         <= AN_OFF;
                  frame_done <= (BLANK_CYC == 1) && (idx == IDX_LAST);
               end
            end
            ST_BLANK: begin
               // Registered pulse lands on the final blank cycle
               if (BLANK_CYC > 1 && cnt == C_TWO && idx == IDX_LAST) begin
                  frame_done <= 1'b1;
               end
               if (done) begin
                  idx <= idx_nxt;
                  if (en) begin
                     st        <= ST_REQ;
                     rd.rd_req <= 1'b1;
                     if (idx_nxt == '0) begin
                        base_q     <= base_addr;
                        rd.rd_addr <= base_addr;
                     end else begin
                        rd.rd_addr <= base_q + ADDR_W'(idx_nxt);
                     end
                  end else begin
                     st <= ST_IDLE;
                  end
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regbank_scan_ctrl.sv
// Randomized bench for regbank_scan_ctrl with a slot-timeline
// reference model and a behavioural register bank.
module tb_regbank_scan_ctrl;
   import regbank_pkg::*;

   localparam int NDIG = 2;
   localparam int AW   = 3;
   localparam int PS   = 4;
   localparam int BC   = 2;
   localparam int RL   = 1;
   localparam logic [NDIG-1:0] AN_OFF = '1;

   logic           clk_e = 1'b0;
   logic           rst   = 1'b0;
   logic           en    = 1'b0;
   logic [AW-1:0]  base_addr = '0;
   logic [NDIG-1:0] an;
   logic [3:0]     bcd;
   logic           frame_done;
   logic [3:0]     mem [8];
   int             n_chk = 0;
   int             n_err = 0;

   regbank_scan_ctrl_if #(.ADDR_W(AW)) bus ();

   regbank_scan_ctrl #(
      .NDIG      (NDIG),
      .ADDR_W    (AW),
      .PRESCALE  (PS),
      .BLANK_CYC (BC),
      .RD_LAT    (RL)
   ) dut (
      .clk_e      (clk_e),
      .rst        (rst),
      .en         (en),
      .base_addr  (base_addr),
      .rd         (bus.master),
      .an         (an),
      .bcd        (bcd),
      .frame_done (frame_done)
   );

   always #5 clk_e = ~clk_e;

   // Bank: data valid one cycle after the grant, garbage otherwise
   always @(posedge clk_e) begin
      if (bus.rd_req && bus.rd_gnt)
         bus.rd_data <= mem[bus.rd_addr];
      else
         bus.rd_data <= 4'($urandom);
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] slot_addr(input logic [AW-1:0] b,
                                               input int i);
      return AW'((int'(b) + i) % (2 ** AW));
   endfunction

   function automatic bit dark(input logic [AW-1:0] b, input int i);
`ifdef LEADING_ZERO_BLANK_EN
      if (i == NDIG - 1) return 1'b0;
      for (int j = 0; j <= i; j++)
         if (mem[slot_addr(b, j)] != 4'd0) return 1'b0;
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic idle_chk(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk_e);
         bus.rd_gnt = 1'($urandom);
         chk("idle_req", bus.rd_req, 1'b0);
         chk("idle_an", an, AN_OFF);
         chk("idle_fd", frame_done, 1'b0);
      end
   endtask

   task automatic do_slot(input logic [AW-1:0] b, input int i,
                          input int hold, input bit drop);
      logic [AW-1:0]   a;
      logic [NDIG-1:0] exp_an;
      a = slot_addr(b, i);
      exp_an = dark(b, i) ? AN_OFF : ~(NDIG'(1) << i);
      for (int n = 0; n <= hold; n++) begin
         @(negedge clk_e);
         chk("req", bus.rd_req, 1'b1);
         chk("addr", bus.rd_addr, a);
         chk("an_req", an, AN_OFF);
         chk("fd_req", frame_done, 1'b0);
         if (i == 1 && n == 0) base_addr = AW'($urandom);
         bus.rd_gnt = (n == hold);
      end
      for (int n = 0; n < RL; n++) begin
         @(negedge clk_e);
         bus.rd_gnt = 1'($urandom);
         chk("wait_req", bus.rd_req, 1'b0);
         chk("wait_an", an, AN_OFF);
      end
      for (int n = 0; n < PS; n++) begin
         @(negedge clk_e);
         bus.rd_gnt = 1'($urandom);
         chk("show_an", an, exp_an);
         chk("show_bcd", bcd, mem[a]);
         chk("show_req", bus.rd_req, 1'b0);
         chk("show_fd", frame_done, 1'b0);
         if (drop && n == 0) en = 1'b0;
      end
      for (int n = 0; n < BC; n++) begin
         @(negedge clk_e);
         bus.rd_gnt = 1'($urandom);
         chk("blank_an", an, AN_OFF);
         chk("blank_req", bus.rd_req, 1'b0);
         chk("blank_fd", frame_done,
             (i == NDIG - 1) && (n == BC - 1));
      end
   endtask

   task automatic do_frame(input int h0, input int h1, input int drop_slot);
      logic [AW-1:0] b;
      b = base_addr;
      do_slot(b, 0, h0, drop_slot == 0);
      if (drop_slot == 0) begin
         idle_chk(6);
         return;
      end
      do_slot(b, 1, h1, drop_slot == 1);
      if (drop_slot == 1) idle_chk(6);
   endtask

   task automatic fill_mem();
      for (int k = 0; k < 8; k++)
         mem[k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
   endtask

   initial begin
      int nf;
      bus.rd_gnt = 1'b0;
      fill_mem();
      repeat (3) @(negedge clk_e);
      chk("rst_an", an, AN_OFF);
      chk("rst_bcd", bcd, 4'd0);
      chk("rst_req", bus.rd_req, 1'b0);
      chk("rst_addr", bus.rd_addr, 3'd0);
      chk("rst_fd", frame_done, 1'b0);
      rst = 1'b1;
      idle_chk(3);

      mem[3] = 4'd5;
      mem[4] = 4'd9;
      base_addr = 3'd3;
      en = 1'b1;
      do_frame(0, 0, 1);

      base_addr = 3'd5;
      en = 1'b1;
      do_frame(10, 3, 1);

      base_addr = 3'd7;
      en = 1'b1;
      do_frame(0, 0, 1);

      base_addr = 3'd2;
      en = 1'b1;
      do_frame(1, 0, 0);

      en = 1'b1;
      @(negedge clk_e);
      chk("wd_req", bus.rd_req, 1'b1);
      en = 1'b0;
      bus.rd_gnt = 1'b0;
      @(negedge clk_e);
      chk("wd_drop", bus.rd_req, 1'b0);
      idle_chk(4);

      base_addr = 3'd1;
      mem[1] = 4'd0;
      mem[2] = 4'd3;
      en = 1'b1;
      do_frame(0, 0, 1);

      for (int r = 0; r < 12; r++) begin
         fill_mem();
         base_addr = AW'($urandom);
         en = 1'b1;
         nf = $urandom_range(1, 3);
         for (int f = 0; f < nf; f++)
            do_frame($urandom_range(0, 4), $urandom_range(0, 4),
                     (f == nf - 1) ? int'($urandom_range(0, 1)) : -1);
      end

      base_addr = 3'd0;
      mem[0] = 4'd6;
      en = 1'b1;
      repeat (4) begin
         @(negedge clk_e);
         bus.rd_gnt = 1'b1;
      end
      chk("pre_rst_an", an, 2'b10);
      rst = 1'b0;
      #1;
      chk("mid_rst_an", an, AN_OFF);
      chk("mid_rst_bcd", bcd, 4'd0);
      chk("mid_rst_req", bus.rd_req, 1'b0);
      chk("mid_rst_fd", frame_done, 1'b0);
      en = 1'b0;
      @(negedge clk_e);
      rst = 1'b1;
      idle_chk(4);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
